inv_key_schedule: RTL and testbench

//  Iterative AES-128 inverse key schedule, the reverse of Keygeneration. Loads the final

---
 rtl/roundsbox.sv | 29 ++
 rtl/inv_key_schedule.sv | 147 ++++++++++++++
 tb/tb_inv_key_schedule.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roundsbox.sv
// rtl/roundsbox.sv - AES forward S-box, single byte lookup shared with the forward key schedule
module roundsbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Byte 0x00 sits in the top byte so the table reads in the usual row order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - iterative AES-128 inverse key schedule, one round key per handshake
// INVKEY_FWD_EN: key_in is the cipher key and a forward pass to round NR precedes emission.
module inv_key_schedule #(
  parameter int NR      = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       key_in,
  input  logic               rk_ready,
  output logic               rk_valid,
  output logic [127:0]       rk_out,
  output logic [ROUND_W-1:0] rk_round,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_EMIT} state_t;

  localparam logic [ROUND_W-1:0] ONE = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] RNR = ROUND_W'(NR);

  state_t             state_q, state_d;
  logic [127:0]       kreg_q, kreg_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               done_q, done_d;

  logic [31:0] w0, w1, w2, w3, p1, p2, p3;
  logic [31:0] sbox_in, rot_w, sub_w;
  logic [127:0] inv_key;

  function automatic logic [31:0] rcon(input logic [ROUND_W-1:0] j);
    logic [7:0] rc;
    case (int'(j))
      0:       rc = 8'h01;
      1:       rc = 8'h02;
      2:       rc = 8'h04;
      3:       rc = 8'h08;
      4:       rc = 8'h10;
      5:       rc = 8'h20;
      6:       rc = 8'h40;
      7:       rc = 8'h80;
      8:       rc = 8'h1b;
      9:       rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  assign w0 = kreg_q[127:96];
  assign w1 = kreg_q[95:64];
  assign w2 = kreg_q[63:32];
  assign w3 = kreg_q[31:0];
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

`ifdef INVKEY_FWD_EN
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] fwd_key;

  // The forward step needs SubWord of w3, the inverse step of the recovered w3 (p3).
  assign sbox_in = (state_q == S_FWD) ? w3 : p3;
  assign n0      = w0 ^ sub_w ^ rcon(round_q);
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign fwd_key = {n0, n1, n2, n3};
`else
  assign sbox_in = p3;
`endif

  assign rot_w = {sbox_in[23:0], sbox_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    roundsbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .y (sub_w[8*i +: 8])
    );
  end

  assign inv_key = {w0 ^ sub_w ^ rcon(round_q - ONE), p1, p2, p3};

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kreg_d  = key_in;
`ifdef INVKEY_FWD_EN
          round_d = '0;
          state_d = S_FWD;
`else
          round_d = RNR;
          state_d = S_EMIT;
`endif
        end
      end
`ifdef INVKEY_FWD_EN
      S_FWD: begin
        kreg_d  = fwd_key;
        round_d = round_q + ONE;
        if (round_q == RNR - ONE) begin
          state_d = S_EMIT;
        end
      end
`endif
      S_EMIT: begin
        if (rk_ready) begin
          if (round_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            kreg_d  = inv_key;
            round_d = round_q - ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kreg_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == S_EMIT);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rk_out   = kreg_q;
  assign rk_round = round_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - randomized bench for inv_key_schedule against a forward-expansion model
module tb_inv_key_schedule;

  localparam int NR = 10;
  localparam int RW = 4;
`ifdef INVKEY_FWD_EN
  localparam bit FWD = 1'b1;
  localparam int LAT = NR + 1;
`else
  localparam bit FWD = 1'b0;
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [127:0]  key_in = '0;
  logic          rk_ready = 1'b0;
  logic          rk_valid;
  logic [127:0]  rk_out;
  logic [RW-1:0] rk_round;
  logic          busy;
  logic          done;

  inv_key_schedule #(.NR(NR), .ROUND_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb    [0:255];
  logic [127:0] xk    [0:NR];
  logic [127:0] pend  [0:NR];
  logic [127:0] sched [0:NR];

  int   m_state = 0;
  int   m_cnt   = 0;
  int   m_idx   = 0;
  logic m_done  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] x;
      for (int v = 1; v < 256; v++) begin
        if (gmul(8'(a), 8'(v)) == 8'h01) inv = 8'(v);
      end
      x = inv;
      sb[a] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
  endtask

  // Textbook AES-128 expansion into 4*(NR+1) words.
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [0:4*NR+3];
    logic [7:0]  rc [0:9];
    logic [31:0] t;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    for (int i = 4; i < 4*NR + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) xk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic prep(input logic [127:0] ck);
    expand(ck);
    for (int r = 0; r <= NR; r++) pend[r] = xk[r];
    key_in = FWD ? ck : xk[NR];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_key(input int r, input string nm);
    int n = 0;
    while (!(rk_valid && int'(rk_round) == r) && n < 300) begin
      step();
      n++;
    end
    chk(nm, 128'(n < 300), 128'(1));
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    chk(nm, 128'(n < 300), 128'(1));
  endtask

  task automatic check_latency(input string nm);
    int lat = 1;
    while (!rk_valid && lat < 50) begin
      step();
      lat++;
    end
    chk(nm, 128'(lat), 128'(LAT));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_idx   <= 0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_state)
        0: if (start) begin
          for (int i = 0; i <= NR; i++) sched[i] <= pend[i];
          if (FWD) begin
            m_state <= 1;
            m_cnt   <= NR;
          end else begin
            m_state <= 2;
            m_idx   <= NR;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_state <= 2;
            m_idx   <= NR;
          end
        end
        default: if (rk_ready) begin
          if (m_idx == 0) begin
            m_state <= 0;
            m_done  <= 1'b1;
          end else begin
            m_idx <= m_idx - 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rk_valid", 128'(rk_valid), 128'(m_state == 2));
      chk("busy", 128'(busy), 128'(m_state != 0));
      chk("done", 128'(done), 128'(m_done));
      if (m_state == 2) begin
        chk("rk_round", 128'(rk_round), 128'(m_idx));
        chk("rk_out", rk_out, sched[m_idx]);
      end
    end
  end

  initial begin
    int acc;
    int n;
    build_sbox();

    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model_rk10", xk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_rk9", xk[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("model_rk1", xk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'(8'hed));

    repeat (3) step();
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_out", rk_out, 128'(0));
    chk("rst_round", 128'(rk_round), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst = 1'b0;
    step();

    // Known-answer schedule with the consumer always ready.
    prep(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk_ready = 1'b1;
    go();
    check_latency("t1_latency");
    chk("t1_first_round", 128'(rk_round), 128'(10));
    chk("t1_first_key", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int k = 1; k <= NR; k++) begin
      step();
      chk("t2_consecutive", 128'(rk_valid), 128'(1));
      if (k == 1) chk("t1_second_key", rk_out, 128'hac7766f319fadc2128d12941575c006e);
      if (k == 9) chk("t2_round1_key", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
      if (k == 10) chk("t2_round0_key", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    end
    step();
    chk("t2_done_pulse", 128'(done), 128'(1));
    step();
    chk("t2_done_once", 128'(done), 128'(0));

    // Random keys under random backpressure.
    for (int s = 0; s < 4; s++) begin
      prep({$urandom, $urandom, $urandom, $urandom});
      go();
      acc = 0;
      n = 0;
      while (!done && n < 500) begin
        rk_ready = 1'($urandom % 2);
        if (rk_valid && rk_ready) acc++;
        step();
        n++;
      end
      chk("t3_accepted", 128'(acc), 128'(NR + 1));
      step();
    end

    // start while busy is ignored; start on the done cycle begins a new schedule.
    rk_ready = 1'b1;
    prep({$urandom, $urandom, $urandom, $urandom});
    go();
    wait_key(5, "t4_reach5");
    key_in = {$urandom, $urandom, $urandom, $urandom};
    go();
    wait_done("t4_done");
    prep({$urandom, $urandom, $urandom, $urandom});
    go();
    if (!FWD) begin
      chk("t4_restart_valid", 128'(rk_valid), 128'(1));
      chk("t4_restart_round", 128'(rk_round), 128'(10));
    end else begin
      chk("t4_restart_busy", 128'(busy), 128'(1));
    end
    wait_done("t4_done2");
    step();

    // Asynchronous reset mid-schedule, then a clean restart.
    prep({$urandom, $urandom, $urandom, $urandom});
    go();
    wait_key(6, "t5_reach6");
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", 128'(rk_valid), 128'(0));
    chk("t5_out", rk_out, 128'(0));
    chk("t5_round", 128'(rk_round), 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_done", 128'(done), 128'(0));
    step();
    step();
    rst = 1'b0;
    prep({$urandom, $urandom, $urandom, $urandom});
    go();
    check_latency("t5_latency");
    chk("t5_restart_round", 128'(rk_round), 128'(10));
    wait_done("t5_done_final");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
